pwm_in_multi: RTL
=================

PWM_IN_MULTI -- requirements
Module: pwm_in_multi

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
- NUM_CH, 4, number of independent input channels (1..16).
- CNT_W, 32, width of period/on-time counters and results.
- DEB_LEN, 3, consecutive equal samples needed to change a debounced level (2..8).
- TIMEOUT_BIT, 28, no-signal declared when period count reaches 2^TIMEOUT_BIT; TIMEOUT_BIT < CNT_W.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- xclk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- pwm_in, in, NUM_CH, raw digital inputs, one per channel, asynchronous to xclk.
- invert, in, NUM_CH, per-channel polarity; 1 = measure the low phase as on-time.
- rd_sel, in, clog2(NUM_CH) (min 1), channel to read.
- rd_strobe, in, 1, one-cycle read request.
- rd_valid, out, 1, one-cycle pulse qualifying rd_* outputs.
- rd_period, out, CNT_W, snapshot period in xclk cycles.
- rd_ontime, out, CNT_W, snapshot on-time in xclk cycles.
- rd_new, out, 1, snapshot had an unread measurement.
- rd_nosig, out, 1, snapshot no-signal status.
- new_meas, out, NUM_CH, per-channel unread-measurement flags.

Function
REQ-003 Each channel SHALL first pass pwm_in through a two-flop synchroniser, then XOR it with invert, then through the debouncer.
REQ-004 The debounced level SHALL change only after DEB_LEN consecutive identical synchronised samples; otherwise it holds.
REQ-005 A rising edge SHALL be the debounced level being 1 in the current cycle and 0 in the previous cycle.
REQ-006 Each channel SHALL run an FSM with states IDLE and RUN; reset enters IDLE.
REQ-007 In IDLE, a rising edge SHALL load period_cnt=1 and ontime_cnt=1 and enter RUN; it SHALL NOT latch results, so partial first periods are discarded.
REQ-008 In RUN with no edge:
- period_cnt SHALL increment every cycle.
- ontime_cnt SHALL increment when the debounced level is 1.
REQ-009 In RUN, a rising edge SHALL:
- latch period_reg=period_cnt and ontime_reg=ontime_cnt;
- reload both counters to 1;
- set new_meas[ch] and clear nosig[ch].
REQ-010 For a stable input of period P cycles and debounced high time H, latched values SHALL be period=P and ontime=H exactly.
REQ-011 When period_cnt reaches 2^TIMEOUT_BIT in RUN, the channel SHALL:
- zero period_reg and ontime_reg;
- set nosig[ch] and clear new_meas[ch];
- enter IDLE.
REQ-012 The channel SHALL stay in IDLE with zeroed results until the next rising edge; counters SHALL NOT wrap.
REQ-013 On rd_strobe, the block SHALL register a coherent snapshot of {period_reg, ontime_reg, new_meas, nosig} for rd_sel into the rd_* outputs; rd_valid SHALL pulse exactly one cycle later.
REQ-014 rd_* outputs SHALL hold between reads; rd_sel >= NUM_CH SHALL return all zeros with rd_valid still pulsing.
REQ-015 A read SHALL clear new_meas[rd_sel]; if a latch event occurs in the same cycle, the snapshot SHALL show the old values and new_meas SHALL remain set (latch wins).
REQ-016 Channels SHALL be fully independent; simultaneous edges on all channels SHALL each be handled in the same cycle.
REQ-017 A change of invert mid-operation SHALL be treated as an input transition (no special handling).

Reset
REQ-018 While reset is high, the block SHALL asynchronously clear:
- all synchroniser and debounce state, and the debounced levels (to 0);
- all counters and result registers (to 0);
- nosig, new_meas, rd_valid, rd_period, rd_ontime, rd_new and rd_nosig (to 0).
REQ-019 All FSMs SHALL be in IDLE during reset.
REQ-020 Reset asserted mid-measurement SHALL discard the measurement; the first edge after release SHALL behave per REQ-007.

Verification
REQ-021 Ch0: square wave P=100, H=25, invert=0; read after 3 periods -> rd_period=100, rd_ontime=25, rd_new=1, rd_nosig=0; immediate re-read -> rd_new=0.
REQ-022 Ch1: same wave with invert[1]=1 -> period=100, ontime=75.
REQ-023 TIMEOUT_BIT=8: stop toggling -> 256 cycles after the last edge nosig=1 and results=0; restart -> first edge gives no latch, second edge latches the correct period.
REQ-024 Glitches of DEB_LEN-1 cycles injected on a P=100 wave -> results unchanged; a DEB_LEN-cycle pulse is detected.
REQ-025 Four channels with periods 50/60/70/80 and coincident edges -> each channel reads correct values; rd_strobe on the latch cycle -> old snapshot and new_meas stays 1.
REQ-026 Reset pulsed mid-period -> all outputs 0; the next two edges produce a correct latch on the second edge only.

Source files
------------

// File: rtl/pwm_in_multi.sv
// Multi-channel PWM capture: per channel sync, debounce, period/on-time measurement and no-signal timeout.
// Results latch on each debounced rising edge; read port is strobe-driven with no backpressure, rd_valid one cycle after rd_strobe.
module pwm_in_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int DEB_LEN     = 3,
   parameter int TIMEOUT_BIT = 28,
   localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              xclk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] pwm_in,
   input  logic [NUM_CH-1:0] invert,
   input  logic [SEL_W-1:0]  rd_sel,
   input  logic              rd_strobe,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_period,
   output logic [CNT_W-1:0]  rd_ontime,
   output logic              rd_new,
   output logic              rd_nosig,
   output logic [NUM_CH-1:0] new_meas
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   localparam int               DCNT_W  = $clog2(DEB_LEN);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(1) << TIMEOUT_BIT;

   logic [CNT_W-1:0]  per_res [NUM_CH];
   logic [CNT_W-1:0]  on_res  [NUM_CH];
   logic [NUM_CH-1:0] nosig;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic              sync1_q, sync2_q, samp;
      logic              deb_q, deb_d, deb_prev_q, rise;
      logic [DCNT_W-1:0] dcnt_q, dcnt_d;
      state_t            state_q, state_d;
      logic [CNT_W-1:0]  per_cnt_q, per_cnt_d, on_cnt_q, on_cnt_d;
      logic [CNT_W-1:0]  per_reg_q, per_reg_d, on_reg_q, on_reg_d;
      logic              new_q, new_d, nosig_q, nosig_d, rd_clr;

      assign samp   = sync2_q ^ invert[c];
      assign rise   = deb_q & ~deb_prev_q;
      assign rd_clr = rd_strobe && (rd_sel == SEL_W'(c));

      // dcnt_q counts consecutive samples that disagree with the debounced level
      always_comb begin : debounce
         deb_d  = deb_q;
         dcnt_d = '0;
         if (samp != deb_q) begin
            if (dcnt_q == DCNT_W'(DEB_LEN - 1)) begin
               deb_d = samp;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
      end

      always_comb begin : fsm
         state_d   = state_q;
         per_cnt_d = per_cnt_q;
         on_cnt_d  = on_cnt_q;
         per_reg_d = per_reg_q;
         on_reg_d  = on_reg_q;
         new_d     = new_q & ~rd_clr;
         nosig_d   = nosig_q;
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  per_cnt_d = CNT_W'(1);
                  on_cnt_d  = CNT_W'(1);
                  state_d   = ST_RUN;
               end
            end
            ST_RUN: begin
               if (rise) begin
                  per_reg_d = per_cnt_q;
                  on_reg_d  = on_cnt_q;
                  per_cnt_d = CNT_W'(1);
                  on_cnt_d  = CNT_W'(1);
                  new_d     = 1'b1;
                  nosig_d   = 1'b0;
               end else if (per_cnt_q == TMO_CNT) begin
                  per_reg_d = '0;
                  on_reg_d  = '0;
                  per_cnt_d = '0;
                  on_cnt_d  = '0;
                  new_d     = 1'b0;
                  nosig_d   = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  per_cnt_d = per_cnt_q + CNT_W'(1);
                  on_cnt_d  = on_cnt_q + CNT_W'(deb_q);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge xclk or posedge reset) begin
         if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            dcnt_q     <= '0;
            state_q    <= ST_IDLE;
            per_cnt_q  <= '0;
            on_cnt_q   <= '0;
            per_reg_q  <= '0;
            on_reg_q   <= '0;
            new_q      <= 1'b0;
            nosig_q    <= 1'b0;
         end else begin
            sync1_q    <= pwm_in[c];
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            on_cnt_q   <= on_cnt_d;
            per_reg_q  <= per_reg_d;
            on_reg_q   <= on_reg_d;
            new_q      <= new_d;
            nosig_q    <= nosig_d;
         end
      end

      assign per_res[c]  = per_reg_q;
      assign on_res[c]   = on_reg_q;
      assign new_meas[c] = new_q;
      assign nosig[c]    = nosig_q;
   end

   logic [CNT_W-1:0] sel_per, sel_on;
   logic             sel_new, sel_nosig;
   logic             rd_valid_q, rd_new_q, rd_nosig_q;
   logic [CNT_W-1:0] rd_period_q, rd_ontime_q;

   // Unmatched selects (rd_sel >= NUM_CH) fall through to zeros
   always_comb begin
      sel_per   = '0;
      sel_on    = '0;
      sel_new   = 1'b0;
      sel_nosig = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(rd_sel) == c) begin
            sel_per   = per_res[c];
            sel_on    = on_res[c];
            sel_new   = new_meas[c];
            sel_nosig = nosig[c];
         end
      end
   end

   always_ff @(posedge xclk or posedge reset) begin
      if (reset) begin
         rd_valid_q  <= 1'b0;
         rd_period_q <= '0;
         rd_ontime_q <= '0;
         rd_new_q    <= 1'b0;
         rd_nosig_q  <= 1'b0;
      end else begin
         rd_valid_q <= rd_strobe;
         if (rd_strobe) begin
            rd_period_q <= sel_per;
            rd_ontime_q <= sel_on;
            rd_new_q    <= sel_new;
            rd_nosig_q  <= sel_nosig;
         end
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_period = rd_period_q;
   assign rd_ontime = rd_ontime_q;
   assign rd_new    = rd_new_q;
   assign rd_nosig  = rd_nosig_q;

endmodule
